// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO result registers.
// A multiply or divide latches its operands at launch, stays busy for a fixed
// number of cycles, then writes HI/LO and pulses done for one cycle.
module mdu_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
  localparam int unsigned PW      = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Datapath on the latched operands; op_q[0]=1 selects the unsigned flavour.
  logic             sgn;
  logic             is_div;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] ua;
  logic [WIDTH-1:0] ub;
  logic [WIDTH-1:0] ub_safe;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  assign sgn    = ~op_q[0];
  assign is_div = op_q[1];
  assign a_neg  = sgn & a_q[WIDTH-1];
  assign b_neg  = sgn & b_q[WIDTH-1];
  assign b_zero = (b_q == '0);

  // Sign- or zero-extend to full width so one multiplier serves both flavours.
  assign a_ext = {{WIDTH{a_neg}}, a_q};
  assign b_ext = {{WIDTH{b_neg}}, b_q};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes, then restore signs: truncation toward zero and a
  // remainder that follows the dividend. MIN / -1 wraps back to MIN, rem 0.
  assign ua      = a_neg ? (-a_q) : a_q;
  assign ub      = b_neg ? (-b_q) : b_q;
  assign ub_safe = b_zero ? WIDTH'(1) : ub;
  assign uq      = ua / ub_safe;
  assign ur      = ua % ub_safe;
  assign q_res   = (a_neg ^ b_neg) ? (-uq) : uq;
  assign r_res   = a_neg ? (-ur) : ur;

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: launch in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              op_d    = op[1:0];
              a_d     = A;
              b_d     = B;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (is_div) begin
            if (!b_zero) begin
              hi_d = r_res;
              lo_d = q_res;
            end
          end else begin
            hi_d = prod[PW-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
